// File: rtl/sha256_round_sched_if.sv
// Block-feed and digest bus between the word feeder, the SHA-256 round
// sequencer and the digest consumer.
interface sha256_round_sched_if;
    logic         start;
    logic         init;
    logic         msg_valid;
    logic [31:0]  msg_word;
    logic         msg_ready;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    modport master (
        output start, init, msg_valid, msg_word,
        input  msg_ready, busy, digest_valid, digest
    );

    modport slave (
        input  start, init, msg_valid, msg_word,
        output msg_ready, busy, digest_valid, digest
    );
endinterface

// File: rtl/sha256_round_sched.sv
// SHA-256 compression sequencer: one round per clock, W schedule from a
// 16-word shift window, chaining state H folded in on the final edge.
module sha256_round_sched (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_sched_if.slave  bus
);

    localparam int unsigned ROUNDS = 64;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {StIdle, StLoad, StExpand, StAdd} state_e;

    state_e      state_q;
    logic [5:0]  t_q;
    logic [31:0] h_q  [8];
    logic [31:0] wv_q [8];   // a..h at indices 0..7
    logic [31:0] w_q  [16];  // w_q[15] = W[t-1], w_q[0] = W[t-16]
    logic        digest_valid_q;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] w_new, t1, t2, ch, maj, bsig0, bsig1, ssig0, ssig1;

    always_comb begin
        ssig0 = rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3);
        ssig1 = rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10);
        w_new = ssig1 + w_q[9] + ssig0 + w_q[0];
        if (state_q == StLoad) begin
            w_new = bus.msg_word;
        end
        bsig0 = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
        bsig1 = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
        ch    = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
        maj   = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
        t1    = wv_q[7] + bsig1 + ch + K[t_q] + w_new;
        t2    = bsig0 + maj;
    end

    // Apply one compression round and push W[t] into the window.
    task automatic do_round();
        wv_q[0] <= t1 + t2;
        wv_q[1] <= wv_q[0];
        wv_q[2] <= wv_q[1];
        wv_q[3] <= wv_q[2];
        wv_q[4] <= wv_q[3] + t1;
        wv_q[5] <= wv_q[4];
        wv_q[6] <= wv_q[5];
        wv_q[7] <= wv_q[6];
        for (int i = 0; i < 15; i++) begin
            w_q[i] <= w_q[i + 1];
        end
        w_q[15] <= w_new;
        t_q     <= t_q + 6'd1;
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            t_q            <= '0;
            digest_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV[i];
                wv_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            digest_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        for (int i = 0; i < 8; i++) begin
                            if (bus.init) begin
                                h_q[i]  <= IV[i];
                                wv_q[i] <= IV[i];
                            end else begin
                                wv_q[i] <= h_q[i];
                            end
                        end
                        t_q     <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.msg_valid) begin
                        do_round();
                        if (t_q == 6'd15) begin
                            state_q <= StExpand;
                        end
                    end
                end
                StExpand: begin
                    do_round();
                    if (t_q == 6'(ROUNDS - 1)) begin
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    for (int i = 0; i < 8; i++) begin
                        h_q[i] <= h_q[i] + wv_q[i];
                    end
                    t_q            <= '0;
                    digest_valid_q <= 1'b1;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.msg_ready    = (state_q == StLoad);
    assign bus.busy         = (state_q != StIdle);
    assign bus.digest_valid = digest_valid_q;
    assign bus.digest       = {h_q[0], h_q[1], h_q[2], h_q[3],
                               h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_round_sched.sv
// Directed bench for sha256_round_sched using known FIPS 180-4 digests.
module tb_sha256_round_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sha256_round_sched_if bus ();

    sha256_round_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    int checks = 0;
    int passes = 0;

    logic [31:0] abc_w   [16];
    logic [31:0] empty_w [16];
    logic [31:0] two1_w  [16];
    logic [31:0] two2_w  [16];

    int lat_s, lat_l, spurious;
    bit got;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Starts a block at the current cycle and returns once digest_valid is seen
    // (sampled 1 time unit after the edge that raised it) or the budget expires.
    task automatic run_block(input logic [31:0] blk [16], input bit ini, input bit stall,
                             input bit start_busy, output int lat_start, output int lat_last,
                             output bit seen);
        int cnt;
        int last;
        int g;
        cnt  = 0;
        seen = 1'b0;
        bus.start = 1'b1;
        bus.init  = ini;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("dv_one_cycle", 256'(bus.digest_valid), 256'd0);
        chk("msg_ready_load", 256'(bus.msg_ready), 256'd1);
        for (int i = 0; i < 16; i++) begin
            g = stall ? int'($urandom_range(0, 3)) : 0;
            repeat (g) begin
                bus.msg_valid = 1'b0;
                bus.msg_word  = 32'hdeadbeef;
                bus.start     = start_busy;
                @(posedge clk);
                #1;
                cnt++;
            end
            bus.start     = 1'b0;
            bus.msg_valid = 1'b1;
            bus.msg_word  = blk[i];
            @(posedge clk);
            #1;
            cnt++;
        end
        last          = cnt;
        bus.msg_valid = 1'b0;
        bus.msg_word  = 32'h0;
        for (int k = 0; k < 200 && !seen; k++) begin
            bus.start = start_busy && (k % 7 == 3);
            @(posedge clk);
            #1;
            cnt++;
            if (bus.digest_valid) seen = 1'b1;
        end
        bus.start = 1'b0;
        lat_start = cnt;
        lat_last  = cnt - last;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc_w[i]   = 32'h0;
            empty_w[i] = 32'h0;
            two2_w[i]  = 32'h0;
        end
        abc_w[0]   = 32'h61626380;
        abc_w[15]  = 32'h00000018;
        empty_w[0] = 32'h80000000;
        two1_w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2_w[15] = 32'h000001c0;

        bus.start     = 1'b0;
        bus.init      = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_word  = 32'h0;

        // Asynchronous reset asserted mid-cycle
        #7 rst_n = 1'b0;
        #1;
        chk("reset_digest", bus.digest, IV_D);
        chk("reset_busy", 256'(bus.busy), 256'd0);
        chk("reset_ready", 256'(bus.msg_ready), 256'd0);
        chk("reset_dv", 256'(bus.digest_valid), 256'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc", unstalled
        run_block(abc_w, 1'b1, 1'b0, 1'b0, lat_s, lat_l, got);
        chk("abc_seen", 256'(got), 256'd1);
        chk("abc_digest", bus.digest, ABC_D);
        chk("abc_lat_start", 256'(lat_s), 256'd65);
        chk("abc_lat_last", 256'(lat_l), 256'd49);
        chk("abc_busy_done", 256'(bus.busy), 256'd0);
        @(posedge clk);
        #1;
        chk("abc_dv_drop", 256'(bus.digest_valid), 256'd0);
        chk("abc_digest_hold", bus.digest, ABC_D);

        // Empty message
        run_block(empty_w, 1'b1, 1'b0, 1'b0, lat_s, lat_l, got);
        chk("empty_digest", bus.digest, EMPTY_D);
        chk("empty_lat_start", 256'(lat_s), 256'd65);

        // Reset while idle restores IV immediately
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("idle_reset_digest", bus.digest, IV_D);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-block message, second start in the digest_valid cycle
        run_block(two1_w, 1'b1, 1'b0, 1'b0, lat_s, lat_l, got);
        chk("two_first_dv", 256'(got), 256'd1);
        run_block(two2_w, 1'b0, 1'b0, 1'b0, lat_s, lat_l, got);
        chk("two_second_dv", 256'(got), 256'd1);
        chk("two_digest", bus.digest, TWO_D);
        chk("two_lat_start", 256'(lat_s), 256'd65);

        // "abc" with random stalls and start pulses while busy
        @(posedge clk);
        #1;
        run_block(abc_w, 1'b1, 1'b1, 1'b1, lat_s, lat_l, got);
        chk("stall_seen", 256'(got), 256'd1);
        chk("stall_digest", bus.digest, ABC_D);
        chk("stall_lat_last", 256'(lat_l), 256'd49);
        @(posedge clk);
        #1;
        chk("stall_idle_after", 256'(bus.busy), 256'd0);

        // Reset during EXPAND at t = 30
        bus.start = 1'b1;
        bus.init  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.msg_valid = 1'b1;
            bus.msg_word  = abc_w[i];
            @(posedge clk);
            #1;
        end
        bus.msg_valid = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 256'(bus.busy), 256'd0);
        chk("midrst_digest", bus.digest, IV_D);
        #2 rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (bus.digest_valid) spurious++;
        end
        chk("midrst_no_dv", 256'(spurious), 256'd0);
        run_block(abc_w, 1'b1, 1'b0, 1'b0, lat_s, lat_l, got);
        chk("midrst_abc_digest", bus.digest, ABC_D);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
